// File: rtl/song_reader.sv
// -----------------------------------------------------------------------------
// song_reader
//
// Walks the note list of the selected song in a synchronous song ROM and times
// each note in beats, presenting the current note to the note player and
// signalling the end of the song with a one-cycle pulse.
//
// Ports
//   clk_i           system clock, all state on the rising edge
//   reset_i         asynchronous, active-high reset
//   play_i          level: 1 = beats advance the song, 0 = paused/frozen
//   reset_player_i  synchronous restart of the current song at index 0
//   song_i          song select (changes only together with reset_player_i)
//   beat_i          one-cycle tick, one per beat
//   rom_addr_o      {song, idx}; combinational from live song_i and idx
//   rom_data_i      {note, duration}; valid the cycle after rom_addr_o
//   note_o          current note; 0 outside PLAYING (code 0 is a timed rest)
//   new_note_o      one-cycle pulse on the first PLAYING cycle of each note
//   song_done_o     one-cycle pulse on song end
//   state_o         current FSM state, for observation only
//
// Handshake contract: there is no valid/ready pair here. A beat counts only when
// play_i && beat_i are both high in PLAYING; any other beat is dropped, never
// queued. The ROM is trusted to return data exactly one cycle after the address.
// -----------------------------------------------------------------------------
module song_reader #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      play_i,
    input  logic                      reset_player_i,
    input  logic [1:0]                song_i,
    input  logic                      beat_i,
    output logic [IDX_W+1:0]          rom_addr_o,
    input  logic [NOTE_W+DUR_W-1:0]   rom_data_i,
    output logic [NOTE_W-1:0]         note_o,
    output logic                      new_note_o,
    output logic                      song_done_o,
    output logic [1:0]                state_o
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        LOAD    = 2'd1,
        PLAYING = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;
    localparam logic [DUR_W-1:0] CNT_ONE  = 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DUR_W-1:0]    cnt_q, cnt_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                new_note_q, new_note_d;
    logic                song_done_q, song_done_d;

    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic                beat_ok;

    assign rom_note = rom_data_i[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data_i[DUR_W-1:0];
    assign beat_ok  = play_i && beat_i;

    // The address follows the live song select so a restart fetches the new
    // song's first entry in the very next cycle.
    assign rom_addr_o  = {song_i, idx_q};
    assign note_o      = note_q;
    assign new_note_o  = new_note_q;
    assign song_done_o = song_done_q;
    assign state_o     = state_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        note_d      = note_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;

        if (reset_player_i) begin
            // Restart wins over everything, including a note ending this cycle.
            state_d = FETCH;
            idx_d   = '0;
            cnt_d   = '0;
            note_d  = '0;
        end else begin
            case (state_q)
                FETCH: begin
                    // Fetch is not gated by play_i; pausing only freezes beats.
                    state_d = LOAD;
                end
                LOAD: begin
                    if (rom_dur != '0) begin
                        note_d     = rom_note;
                        cnt_d      = rom_dur;
                        new_note_d = 1'b1;
                        state_d    = PLAYING;
                    end else begin
                        // Zero duration marks the end of the song.
                        song_done_d = 1'b1;
                        state_d     = DONE;
                    end
                end
                PLAYING: begin
                    if (beat_ok) begin
                        if (cnt_q == CNT_ONE) begin
                            note_d = '0;
                            cnt_d  = '0;
                            if (idx_q == IDX_LAST) begin
                                // Last slot played: stop, no wrap to index 0.
                                song_done_d = 1'b1;
                                state_d     = DONE;
                            end else begin
                                idx_d   = idx_q + IDX_ONE;
                                state_d = FETCH;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= FETCH;
            idx_q       <= '0;
            cnt_q       <= '0;
            note_q      <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            note_q      <= note_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// -----------------------------------------------------------------------------
// tb_song_reader
//
// Directed bench for song_reader with a behavioural synchronous song ROM.
// Expected notes and end-of-song pulses are queued when a song is started and
// retired whenever the reader pulses new_note / song_done.
// -----------------------------------------------------------------------------
module tb_song_reader;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int IDX_W  = 5;

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_PLAYING = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic                     play;
    logic                     reset_player;
    logic [1:0]               song;
    logic                     beat;
    logic [IDX_W+1:0]         rom_addr;
    logic [NOTE_W+DUR_W-1:0]  rom_data;
    logic [NOTE_W-1:0]        note;
    logic                     new_note;
    logic                     song_done;
    logic [1:0]               state;

    song_reader #(
        .NOTE_W (NOTE_W),
        .DUR_W  (DUR_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .play_i         (play),
        .reset_player_i (reset_player),
        .song_i         (song),
        .beat_i         (beat),
        .rom_addr_o     (rom_addr),
        .rom_data_i     (rom_data),
        .note_o         (note),
        .new_note_o     (new_note),
        .song_done_o    (song_done),
        .state_o        (state)
    );

    // ---------------- song ROM model ----------------
    logic [NOTE_W+DUR_W-1:0] rom [128];

    always @(posedge clk) rom_data <= rom[rom_addr];

    // ---------------- scoreboard ----------------
    logic [NOTE_W-1:0] exp_q[$];
    bit                exp_done_q[$];
    int                n_pass;
    int                n_total;
    int                n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        logic [NOTE_W-1:0] e;
        if (new_note === 1'b1) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_note", {26'd0, note}, {26'd0, e});
            end else begin
                check("sb_spurious_new_note", {31'd0, new_note}, 32'd0);
            end
        end
        if (song_done === 1'b1) begin
            if (exp_done_q.size() > 0) begin
                void'(exp_done_q.pop_front());
                check("sb_song_done_pulse", {31'd0, song_done}, 32'd1);
            end else begin
                check("sb_spurious_song_done", {31'd0, song_done}, 32'd0);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive beat for the coming edge, then sample 1 time unit after it.
    task automatic step(input logic b);
        beat = b;
        @(posedge clk);
        #1;
        beat = 1'b0;
        sb_check();
    endtask

    // One beat every 4 cycles.
    task automatic beat4();
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
    endtask

    function automatic logic [NOTE_W+DUR_W-1:0] ent(input int n, input int d);
        logic [NOTE_W-1:0] nn;
        logic [DUR_W-1:0]  dd;
        nn = NOTE_W'(n);
        dd = DUR_W'(d);
        return {nn, dd};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        n_pass       = 0;
        n_total      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        play         = 1'b0;
        reset_player = 1'b0;
        song         = 2'd0;
        beat         = 1'b0;

        for (int i = 0; i < 128; i++) rom[i] = '0;
        // song 1: note 5 x3, note 7 x4, end marker
        rom[7'h20] = ent(5, 3);
        rom[7'h21] = ent(7, 4);
        rom[7'h22] = ent(0, 0);
        // song 2: note 3 x2, end marker
        rom[7'h40] = ent(3, 2);
        // song 3: 32 notes of one beat each, no marker
        for (int i = 0; i < 32; i++) rom[7'h60 + i] = ent(i + 1, 1);

        // ---- reset state ----
        step(1'b0);
        check("rst_state", {30'd0, state}, {30'd0, S_FETCH});
        check("rst_note", {26'd0, note}, 32'd0);
        check("rst_new_note", {31'd0, new_note}, 32'd0);
        check("rst_song_done", {31'd0, song_done}, 32'd0);
        check("rst_rom_addr", {25'd0, rom_addr}, 32'h00);

        // ---- basic note ----
        song         = 2'd1;
        reset_player = 1'b1;
        reset        = 1'b0;
        play         = 1'b1;
        exp_q.push_back(6'd5);
        exp_q.push_back(6'd7);
        exp_done_q.push_back(1'b1);
        step(1'b0);
        reset_player = 1'b0;
        check("basic_fetch_state", {30'd0, state}, {30'd0, S_FETCH});
        check("basic_fetch_addr", {25'd0, rom_addr}, 32'h20);
        step(1'b0);
        check("basic_load_state", {30'd0, state}, {30'd0, S_LOAD});
        step(1'b0);
        check("basic_new_note", {31'd0, new_note}, 32'd1);
        check("basic_play_state", {30'd0, state}, {30'd0, S_PLAYING});
        beat4();
        beat4();
        check("basic_hold_note", {26'd0, note}, 32'd5);
        check("basic_hold_state", {30'd0, state}, {30'd0, S_PLAYING});
        beat4();
        check("basic_end_state", {30'd0, state}, {30'd0, S_FETCH});
        check("basic_end_addr", {25'd0, rom_addr}, 32'h21);
        check("basic_end_note", {26'd0, note}, 32'd0);

        // ---- pause ----
        step(1'b0);
        step(1'b0);
        check("pause_note_start", {26'd0, note}, 32'd7);
        beat4();
        beat4();
        play = 1'b0;
        for (int k = 0; k < 10; k++) beat4();
        check("pause_note_held", {26'd0, note}, 32'd7);
        check("pause_state_held", {30'd0, state}, {30'd0, S_PLAYING});
        check("pause_addr_held", {25'd0, rom_addr}, 32'h21);
        play = 1'b1;
        beat4();
        check("resume_1st_beat_state", {30'd0, state}, {30'd0, S_PLAYING});
        beat4();
        check("resume_2nd_beat_state", {30'd0, state}, {30'd0, S_FETCH});
        check("resume_2nd_beat_addr", {25'd0, rom_addr}, 32'h22);

        // ---- end marker ----
        step(1'b0);
        check("marker_load_no_done", {31'd0, song_done}, 32'd0);
        step(1'b0);
        check("marker_song_done", {31'd0, song_done}, 32'd1);
        check("marker_state", {30'd0, state}, {30'd0, S_DONE});
        check("marker_note", {26'd0, note}, 32'd0);
        for (int k = 0; k < 50; k++) beat4();
        check("done_stays_state", {30'd0, state}, {30'd0, S_DONE});
        check("done_stays_pulse", {31'd0, song_done}, 32'd0);
        check("done_stays_note", {26'd0, note}, 32'd0);

        // ---- full song, beat on the LOAD->PLAYING edge is ignored ----
        song         = 2'd3;
        reset_player = 1'b1;
        for (int i = 0; i < 32; i++) exp_q.push_back(NOTE_W'(i + 1));
        exp_done_q.push_back(1'b1);
        step(1'b0);
        reset_player = 1'b0;
        check("full_start_addr", {25'd0, rom_addr}, 32'h60);
        for (int i = 0; i < 32; i++) begin
            step(1'b0);
            step(1'b1);
            step(1'b1);
            if (i < 31) check("full_next_addr", {25'd0, rom_addr}, 32'h60 + i + 1);
        end
        check("full_done_pulse", {31'd0, song_done}, 32'd1);
        check("full_done_state", {30'd0, state}, {30'd0, S_DONE});
        check("full_done_addr", {25'd0, rom_addr}, 32'h7F);
        for (int k = 0; k < 3; k++) step(1'b1);
        check("full_no_wrap_addr", {25'd0, rom_addr}, 32'h7F);
        check("full_no_wrap_state", {30'd0, state}, {30'd0, S_DONE});

        // ---- restart coincident with terminating beat ----
        song         = 2'd1;
        reset_player = 1'b1;
        exp_q.push_back(6'd5);
        step(1'b0);
        reset_player = 1'b0;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        song         = 2'd2;
        reset_player = 1'b1;
        step(1'b1);
        reset_player = 1'b0;
        check("restart_state", {30'd0, state}, {30'd0, S_FETCH});
        check("restart_addr", {25'd0, rom_addr}, 32'h40);
        check("restart_note", {26'd0, note}, 32'd0);
        check("restart_new_note", {31'd0, new_note}, 32'd0);
        check("restart_song_done", {31'd0, song_done}, 32'd0);
        exp_q.push_back(6'd3);
        step(1'b0);
        step(1'b0);
        check("restart_play_note", {26'd0, note}, 32'd3);

        // ---- async reset between edges while PLAYING ----
        #2;
        reset = 1'b1;
        #1;
        check("areset_note", {26'd0, note}, 32'd0);
        check("areset_new_note", {31'd0, new_note}, 32'd0);
        check("areset_song_done", {31'd0, song_done}, 32'd0);
        check("areset_state", {30'd0, state}, {30'd0, S_FETCH});
        step(1'b0);
        check("areset_addr", {25'd0, rom_addr}, 32'h40);
        #2;
        reset = 1'b0;
        exp_q.push_back(6'd3);
        step(1'b0);
        check("after_areset_load", {30'd0, state}, {30'd0, S_LOAD});
        step(1'b0);
        check("after_areset_play", {30'd0, state}, {30'd0, S_PLAYING});

        // ---- final report ----
        check("sb_notes_drained", exp_q.size(), 32'd0);
        check("sb_done_drained", exp_done_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
